sram_rw_port_ctrl: RTL
======================

Name: sram_rw_port_ctrl

Overview:
- Requester-side controller that drives the single-port masked SRAM macro interface: RW0 clk/addr/en/wmode/wmask/wdata out, rdata in.
- Converts one valid/ready request channel (read or masked write) into RW0 accesses.
- Absorbs the macro's 1-cycle read latency into a response FIFO with valid/ready backpressure, so no read data is lost.
- Sits between pipeline logic and any 256x8-class `*_ext` SRAM macro.

Parameters:
- ADDR_W, 8, SRAM address width; depth = 2^ADDR_W.
- DATA_W, 8, SRAM word width.
- MASK_W, 8, write-mask bits; granularity = DATA_W/MASK_W; DATA_W % MASK_W == 0 required.
- RSP_DEPTH, 2, response FIFO entries; >= 1.

Ports:
- clock  input  1  sole clock.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when valid&&ready.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wmask  input  MASK_W  write byte/bit-segment enables.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  consumer accepts read data.
- rsp_data  output  DATA_W  read data, in request order.
- idle  output  1  no read in flight, FIFO empty, not initialising.
- RW0_clk  output  1  = clock.
- RW0_addr  output  ADDR_W  macro address.
- RW0_en  output  1  macro enable.
- RW0_wmode  output  1  macro write mode.
- RW0_wmask  output  MASK_W  macro write mask.
- RW0_wdata  output  DATA_W  macro write data.
- RW0_rdata  input  DATA_W  macro read data, valid the cycle after a read enable.

Behaviour:
- Reset (reset_n low, asynchronous): FIFO empty, pointers/count 0, rd_inflight 0.
  - Outputs held: req_ready 0, rsp_valid 0, RW0_en 0.
  - idle is 1, or 0 when SRAM_CTRL_INIT_EN is defined.
  - A read in flight when reset asserts is discarded.
- RW0 outputs are combinational from the request in RUN state:
  - RW0_en = req_valid && req_ready.
  - RW0_wmode = req_write; RW0_addr = req_addr; RW0_wmask = req_wmask; RW0_wdata = req_wdata.
  - The macro samples the access at the same edge the handshake completes.
- req_ready, RUN state:
  - Writes: 1 unconditionally.
  - Reads: 1 iff fifo_count + rd_inflight < RSP_DEPTH (credit check). Slots freed by a same-cycle rsp pop do not count.
- Read pipeline:
  - Read accepted in cycle N sets rd_inflight.
  - During cycle N+1, RW0_rdata is captured into the FIFO tail at the end of N+1.
  - rsp_valid is first high in cycle N+2. Fixed latency 2 with no backpressure.
  - A write issued in N+1 does not corrupt the captured value; the capture is the pre-write word.
- rd_inflight: set on read accept, cleared the following cycle unless a new read is accepted. Back-to-back reads sustain 1 per cycle while credits allow.
- FIFO:
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo RSP_DEPTH.
  - rsp_data = head entry.
  - Holds stable while rsp_valid && !rsp_ready.
- Write with req_wmask == 0: still accepted and issued with RW0_en 1; memory unchanged.
- Same-address write then read: read returns the new value (the macro completed the write at the earlier edge).
- idle = !rd_inflight && fifo_count == 0 && state == RUN.

Optional Feature:
- Macro: SRAM_CTRL_INIT_EN.
- Defined: state machine INIT -> RUN.
  - Reset enters INIT with init counter 0.
  - In INIT, each cycle: RW0_en 1, RW0_wmode 1, RW0_wmask all ones, RW0_wdata 0, RW0_addr = counter; req_ready 0; idle 0.
  - Counter increments each cycle. After address 2^ADDR_W-1 is written, go to RUN (256 cycles for the defaults).
  - Reset during INIT restarts at address 0.
- Not defined: the block resets directly into RUN; no INIT state or counter exists; SRAM contents after reset are undefined.

Test Plan:
- Write addr 0x10 data 0xA5 mask 0xFF, then read 0x10 -> RW0_en pulses once each; rsp_valid 2 cycles after read accept; rsp_data 0xA5.
- Pre-write 0xFF at 0x20, then write 0x00 mask 0x0F, read 0x20 -> rsp_data 0xF0.
- rsp_ready 0, reads to 0x01, 0x02, 0x03 issued back-to-back -> first two accepted, req_ready 0 for the third. Then rsp_ready 1 -> data returned in order; third read accepted after a slot frees.
- Read 0x30 (holding 0x11) in cycle N, write 0x30 = 0x22 in N+1 -> rsp_data 0x11; a later read returns 0x22.
- Assert reset_n low the cycle after a read accept -> rsp_valid never rises; FIFO empty and idle 1 after release (macro undefined).
- SRAM_CTRL_INIT_EN defined -> req_ready 0 for 256 cycles with writes to addresses 0..255 of data 0. Then idle 1, and a read of 0x7F returns 0x00.

Source files
------------

// File: rtl/sram_rw_port_ctrl_if.sv
// Request/response channel and RW0 macro pins shared by sram_rw_port_ctrl and its environment.
interface sram_rw_port_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int MASK_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [MASK_W-1:0] req_wmask;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              RW0_clk;
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [MASK_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wmask, req_wdata, rsp_ready, RW0_rdata,
    output req_ready, rsp_valid, rsp_data,
    output RW0_clk, RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wmask, req_wdata, rsp_ready, RW0_rdata,
    input  req_ready, rsp_valid, rsp_data,
    input  RW0_clk, RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata
  );
endinterface

// File: rtl/sram_rw_port_ctrl.sv
// Single-port masked SRAM requester: one req channel to RW0 accesses, read data buffered in a response FIFO.
// Define SRAM_CTRL_INIT_EN to zero-fill the macro after reset.
//   state   | meaning
//   ST_INIT | zero-fill sweep over every address, requests stalled
//   ST_RUN  | normal request service
module sram_rw_port_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MASK_W    = 8,
  parameter int RSP_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               idle,
  sram_rw_port_ctrl_if.slave bus
);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 2);

  logic [DATA_W-1:0] r_fifo [RSP_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_rd_inflight;

  logic w_run;
  logic w_state_run;
  logic w_credit;
  logic w_accept;
  logic w_rd_accept;
  logic w_push;
  logic w_pop;

`ifdef SRAM_CTRL_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_init_addr;
  logic              w_init;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_INIT;
      r_init_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_init_addr <= r_init_addr + ADDR_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_init_addr == '1) w_state_nxt = ST_RUN;
  end

  assign w_state_run = (r_state == ST_RUN);
  assign w_run       = reset_n && w_state_run;
  assign w_init      = reset_n && (r_state == ST_INIT);
`else
  assign w_state_run = 1'b1;
  assign w_run       = reset_n;
`endif

  // Credits count the in-flight read so the capture slot is guaranteed at acceptance.
  assign w_credit    = (r_count + CNT_W'(r_rd_inflight)) < CNT_W'(RSP_DEPTH);
  assign bus.req_ready = w_run && (bus.req_write || w_credit);
  assign w_accept    = bus.req_valid && bus.req_ready;
  assign w_rd_accept = w_accept && !bus.req_write;

  assign w_push = r_rd_inflight;
  assign w_pop  = bus.rsp_valid && bus.rsp_ready;

  assign bus.rsp_valid = (r_count != '0);
  assign bus.rsp_data  = r_fifo[r_rd_ptr];
  assign idle          = !r_rd_inflight && (r_count == '0) && w_state_run;
  assign bus.RW0_clk   = clock;

  always_comb begin
    bus.RW0_en    = w_accept;
    bus.RW0_wmode = bus.req_write;
    bus.RW0_addr  = bus.req_addr;
    bus.RW0_wmask = bus.req_wmask;
    bus.RW0_wdata = bus.req_wdata;
`ifdef SRAM_CTRL_INIT_EN
    if (w_init) begin
      bus.RW0_en    = 1'b1;
      bus.RW0_wmode = 1'b1;
      bus.RW0_addr  = r_init_addr;
      bus.RW0_wmask = '1;
      bus.RW0_wdata = '0;
    end
`endif
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_inflight <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_rd_inflight <= w_rd_accept;
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Macro read data is valid for exactly the cycle after the enable.
  always_ff @(posedge clock) begin
    if (w_push) r_fifo[r_wr_ptr] <= bus.RW0_rdata;
  end
endmodule
